mm_cmd_sequencer: RTL and testbench

- Command sequencer between the UART byte interfaces and the matrix-multiply datapath inside the neural chip top level.
- Parses opcode bytes from UART RX and writes operand bytes into the A or B operand buffers.
- Starts the multiplier, waits for done with a timeout, then streams results MSB-first to UART TX.
- Owns all status and error byte generation. Sole master of the operand-buffer write port and the result read port.

---
 rtl/mm_cmd_pkg.sv | 28 ++
 rtl/mm_cmd_sequencer_if.sv | 39 +++
 rtl/mm_cmd_sequencer_tx_pacer.sv | 44 ++++
 rtl/mm_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_mm_cmd_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_cmd_pkg.sv
// Shared definitions for the matrix-multiply command sequencer:
// opcodes, reply bytes, FSM state encoding and a width helper.
package mm_cmd_pkg;

  localparam logic [7:0] OP_LOAD_A = 8'hA1;
  localparam logic [7:0] OP_LOAD_B = 8'hB2;
  localparam logic [7:0] OP_RUN    = 8'hC3;

  localparam logic [7:0] ACK_BYTE  = 8'h55;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ACK    = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    RD     = 3'd5,
    SEND   = 3'd6,
    ERR_TX = 3'd7
  } state_e;

  // Index width for n elements; a single element still needs one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_cmd_sequencer_if.sv
// Byte/bus bundle between the command sequencer and its neighbours
// (UART RX/TX, operand buffers, multiplier, result memory).
interface mm_cmd_sequencer_if
  import mm_cmd_pkg::*;
#(
  parameter int DIM   = 2,
  parameter int RES_W = 16
);
  localparam int ADDR_W = addr_width(DIM * DIM);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              buf_we;
  logic              buf_sel;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic              mult_start;
  logic              mult_done;
  logic [ADDR_W-1:0] res_addr;
  logic [RES_W-1:0]  res_data;
  logic              busy;
  logic              err;

  modport master (
    input  rx_data, rx_valid, tx_busy, mult_done, res_data,
    output tx_data, tx_start, buf_we, buf_sel, buf_addr, buf_wdata,
           mult_start, res_addr, busy, err
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, mult_done, res_data,
    input  tx_data, tx_start, buf_we, buf_sel, buf_addr, buf_wdata,
           mult_start, res_addr, busy, err
  );

endinterface

// File: rtl/mm_cmd_sequencer_tx_pacer.sv
// UART TX launcher. Accepts a byte request, launches one frame when the
// transmitter is idle and the previous launch is old enough that TX_BUSY
// would already be visible, and strobes "sent" in the accept cycle.
module mm_cmd_sequencer_tx_pacer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] req_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       sent
);

  logic [1:0] holdoff_r;
  logic       tx_start_r;
  logic [7:0] tx_data_r;

  // TX_BUSY only rises the cycle after TX_START, so a short holdoff
  // bridges the window in which the UART still looks idle.
  assign sent     = req && !tx_busy && (holdoff_r == 2'd0);
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

  // Launch register: one start pulse per accepted request, data held until next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      holdoff_r  <= 2'd0;
    end else begin
      tx_start_r <= sent;
      if (sent) begin
        tx_data_r <= req_data;
        holdoff_r <= 2'd2;
      end else if (holdoff_r != 2'd0) begin
        holdoff_r <= holdoff_r - 2'd1;
      end else begin
        holdoff_r <= holdoff_r;
      end
    end
  end

endmodule

// File: rtl/mm_cmd_sequencer.sv
// Command sequencer: parses UART opcodes, loads operand buffers, runs the
// multiplier with a done timeout and streams results MSB byte first.
module mm_cmd_sequencer
  import mm_cmd_pkg::*;
#(
  parameter int DIM     = 2,
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  mm_cmd_sequencer_if.master bus
);

  localparam int N      = DIM * DIM;
  localparam int ADDR_W = addr_width(N);
  localparam int NB     = RES_W / 8;
  localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(N - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NB - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(TIMEOUT - 1);

  state_e              state_r, state_n;
  logic [ADDR_W-1:0]   elem_r, elem_n;
  logic [ADDR_W-1:0]   res_addr_r, res_addr_n;
  logic [BYTE_W-1:0]   byte_r, byte_n;
  logic [TMO_W-1:0]    tmo_r, tmo_n;
  logic [RES_W-1:0]    shift_r, shift_n;
  logic                rd_phase_r, rd_phase_n;
  logic                buf_sel_r, buf_sel_n;
  logic                mult_start_r, mult_start_n;
  logic                err_r, err_set_s;
  logic                tx_req_s;
  logic [7:0]          tx_byte_s;
  logic                tx_sent_s;
  logic                load_we_s;
  logic [DATA_W-1:0]   wdata_s;

  mm_cmd_sequencer_tx_pacer u_tx_pacer (
    .clk      (clk),
    .rst      (rst),
    .req      (tx_req_s),
    .req_data (tx_byte_s),
    .tx_busy  (bus.tx_busy),
    .tx_start (bus.tx_start),
    .tx_data  (bus.tx_data),
    .sent     (tx_sent_s)
  );

  // Operand writes are combinational so a load byte lands in its own cycle.
  assign load_we_s      = (state_r == LOAD) && bus.rx_valid;
  assign wdata_s        = bus.rx_data;
  assign bus.buf_we     = load_we_s;
  assign bus.buf_sel    = buf_sel_r;
  assign bus.buf_addr   = elem_r;
  assign bus.buf_wdata  = load_we_s ? wdata_s : {DATA_W{1'b0}};
  assign bus.mult_start = mult_start_r;
  assign bus.res_addr   = res_addr_r;
  assign bus.busy       = (state_r != IDLE);
  assign bus.err        = err_r;

  // Next-state and datapath control for the command FSM.
  always_comb begin
    state_n      = state_r;
    elem_n       = elem_r;
    res_addr_n   = res_addr_r;
    byte_n       = byte_r;
    tmo_n        = tmo_r;
    shift_n      = shift_r;
    rd_phase_n   = rd_phase_r;
    buf_sel_n    = buf_sel_r;
    mult_start_n = 1'b0;
    err_set_s    = 1'b0;
    tx_req_s     = 1'b0;
    tx_byte_s    = 8'h00;

    case (state_r)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == OP_LOAD_A) begin
            state_n   = LOAD;
            buf_sel_n = 1'b0;
            elem_n    = {ADDR_W{1'b0}};
          end else if (bus.rx_data == OP_LOAD_B) begin
            state_n   = LOAD;
            buf_sel_n = 1'b1;
            elem_n    = {ADDR_W{1'b0}};
          end else if (bus.rx_data == OP_RUN) begin
            state_n      = START;
            mult_start_n = 1'b1;
          end else begin
            state_n   = ERR_TX;
            err_set_s = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (bus.rx_valid) begin
          if (elem_r == LAST_ELEM) begin
            state_n = ACK;
            elem_n  = {ADDR_W{1'b0}};
          end else begin
            elem_n = elem_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_n = LOAD;
        end
      end
      ACK: begin
        tx_req_s  = 1'b1;
        tx_byte_s = ACK_BYTE;
        if (tx_sent_s) begin
          state_n = IDLE;
        end else begin
          state_n = ACK;
        end
      end
      START: begin
        tmo_n   = {TMO_W{1'b0}};
        state_n = WAIT;
      end
      WAIT: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (bus.mult_done) begin
          state_n    = RD;
          elem_n     = {ADDR_W{1'b0}};
          res_addr_n = {ADDR_W{1'b0}};
          rd_phase_n = 1'b0;
        end else if (tmo_r == LAST_TMO) begin
          state_n   = ERR_TX;
          err_set_s = 1'b1;
        end else begin
          tmo_n = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      RD: begin
        // First cycle lets the result memory settle on the new address.
        if (rd_phase_r) begin
          shift_n    = bus.res_data;
          byte_n     = {BYTE_W{1'b0}};
          rd_phase_n = 1'b0;
          state_n    = SEND;
        end else begin
          rd_phase_n = 1'b1;
        end
      end
      SEND: begin
        tx_req_s  = 1'b1;
        tx_byte_s = shift_r[RES_W-1 -: 8];
        if (tx_sent_s) begin
          shift_n = shift_r << 8;
          if (byte_r == LAST_BYTE) begin
            byte_n = {BYTE_W{1'b0}};
            if (elem_r == LAST_ELEM) begin
              state_n = IDLE;
            end else begin
              elem_n     = elem_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              res_addr_n = elem_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              rd_phase_n = 1'b0;
              state_n    = RD;
            end
          end else begin
            byte_n = byte_r + {{(BYTE_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_n = SEND;
        end
      end
      ERR_TX: begin
        tx_req_s  = 1'b1;
        tx_byte_s = ERR_BYTE;
        if (tx_sent_s) begin
          state_n = IDLE;
        end else begin
          state_n = ERR_TX;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A byte arriving while the sequencer cannot accept it is dropped and flagged.
    if (bus.rx_valid && (state_r != IDLE) && (state_r != LOAD)) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = err_set_s;
    end
  end

  // State, counters, result shifter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      elem_r       <= {ADDR_W{1'b0}};
      res_addr_r   <= {ADDR_W{1'b0}};
      byte_r       <= {BYTE_W{1'b0}};
      tmo_r        <= {TMO_W{1'b0}};
      shift_r      <= {RES_W{1'b0}};
      rd_phase_r   <= 1'b0;
      buf_sel_r    <= 1'b0;
      mult_start_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_n;
      elem_r       <= elem_n;
      res_addr_r   <= res_addr_n;
      byte_r       <= byte_n;
      tmo_r        <= tmo_n;
      shift_r      <= shift_n;
      rd_phase_r   <= rd_phase_n;
      buf_sel_r    <= buf_sel_n;
      mult_start_r <= mult_start_n;
      err_r        <= err_r | err_set_s;
    end
  end

endmodule

// File: tb/tb_mm_cmd_sequencer.sv
// Directed self-checking bench for mm_cmd_sequencer with a UART TX model,
// a multiplier/result-memory model and activity logs.
module tb_mm_cmd_sequencer;
  import mm_cmd_pkg::*;

  localparam int DIM     = 2;
  localparam int N       = 4;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 1023;
  localparam int FRAME   = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mm_cmd_sequencer_if #(.DIM(DIM), .RES_W(RES_W)) bus ();

  mm_cmd_sequencer #(.DIM(DIM), .DATA_W(8), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       hold_busy = 1'b0;
  int         busy_cnt  = 0;
  logic       done_en   = 1'b1;
  int         done_cnt  = 0;
  logic [RES_W-1:0] res_mem [0:N-1] = '{16'h0013, 16'h0016, 16'h002B, 16'h0032};
  logic [7:0] exp_stream [0:7] = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};

  logic [7:0]  tx_q [$];
  logic [10:0] wr_q [$];
  int mstart_cnt = 0;
  int start_busy_cnt = 0;
  int tx_cnt = 0;

  assign bus.tx_busy = hold_busy | (busy_cnt != 0);

  // UART TX and multiplier/result-memory models.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt      <= 0;
      done_cnt      <= 0;
      bus.mult_done <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      if (bus.tx_start) busy_cnt <= FRAME;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      bus.mult_done <= 1'b0;
      if (bus.mult_start && done_en) done_cnt <= 10;
      else if (done_cnt != 0) begin
        done_cnt <= done_cnt - 1;
        if (done_cnt == 1) bus.mult_done <= 1'b1;
      end
      bus.res_data <= res_mem[bus.res_addr];
    end
  end

  // Activity logs for TX bytes, buffer writes and multiplier starts.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.tx_start) begin
        tx_q.push_back(bus.tx_data);
        tx_cnt++;
        if (bus.tx_busy) start_busy_cnt++;
      end
      if (bus.buf_we) wr_q.push_back({bus.buf_sel, bus.buf_addr, bus.buf_wdata});
      if (bus.mult_start) mstart_cnt++;
    end
  end

  function automatic logic [25:0] outs();
    return {bus.tx_start, bus.tx_data, bus.buf_we, bus.buf_sel, bus.buf_addr,
            bus.buf_wdata, bus.mult_start, bus.res_addr, bus.busy, bus.err};
  endfunction

  task automatic clear_log();
    tx_q.delete();
    wr_q.delete();
    mstart_cnt = 0;
    start_busy_cnt = 0;
    tx_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b err=%b want 0 0", bus.busy, bus.err);
    end
  endtask

  task automatic test_load(input logic [7:0] op, input logic sel, input logic [7:0] base);
    bit ok;
    int found;
    logic [10:0] e;
    clear_log();
    send_byte(op);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.rx_data  = base + 8'(i);
      bus.rx_valid = 1'b1;
      #1;
      checks++;
      if (bus.buf_we !== 1'b1 || bus.buf_sel !== sel || bus.buf_addr !== 2'(i) ||
          bus.buf_wdata !== base + 8'(i)) begin
        errors++;
        $display("FAIL load_write%0d: we=%b sel=%b addr=%0d data=%h want 1 %b %0d %h",
                 i, bus.buf_we, bus.buf_sel, bus.buf_addr, bus.buf_wdata, sel, i, base + 8'(i));
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    found = 0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1 && found == 0) found = i;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL load_ack_latency: no tx_start within 2 cycles of last byte");
    end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_idle_timeout: busy=%b want 0", bus.busy);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== ACK_BYTE) begin
      errors++;
      $display("FAIL load_ack_byte: count=%0d first=%h want 1 55", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'h00);
    end
    checks++;
    if (wr_q.size() != N) begin
      errors++;
      $display("FAIL load_write_count: got %0d want %0d", wr_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        e = {sel, 2'(i), base + 8'(i)};
        checks++;
        if (wr_q[i] !== e) begin
          errors++;
          $display("FAIL load_log%0d: got %h want %h", i, wr_q[i], e);
        end
      end
    end
  endtask

  task automatic test_run();
    bit ok;
    clear_log();
    send_byte(OP_RUN);
    checks++;
    if (bus.mult_start !== 1'b1) begin
      errors++;
      $display("FAIL run_start_latency: mult_start=%b want 1", bus.mult_start);
    end
    @(negedge clk);
    checks++;
    if (bus.mult_start !== 1'b0) begin
      errors++;
      $display("FAIL run_start_pulse: mult_start=%b want 0", bus.mult_start);
    end
    wait_idle(600, ok);
    checks++;
    if (!ok || tx_q.size() != 8) begin
      errors++;
      $display("FAIL run_stream_len: idle=%0d bytes=%0d want 1 8", ok, tx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (tx_q[i] !== exp_stream[i]) begin
          errors++;
          $display("FAIL run_byte%0d: got %h want %h", i, tx_q[i], exp_stream[i]);
        end
      end
    end
    checks++;
    if (bus.err !== 1'b0 || mstart_cnt != 1 || start_busy_cnt != 0) begin
      errors++;
      $display("FAIL run_status: err=%b starts=%0d tx_while_busy=%0d want 0 1 0", bus.err, mstart_cnt, start_busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit hit;
    int n0;
    int bad;
    clear_log();
    send_byte(OP_RUN);
    hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx_q.size() >= 3 && busy_cnt != 0) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL bp_reach_mid: bytes=%0d want >=3", tx_q.size());
    end
    hold_busy = 1'b1;
    n0 = tx_cnt;
    repeat (100) @(negedge clk);
    checks++;
    if (tx_cnt != n0) begin
      errors++;
      $display("FAIL bp_held: starts during hold=%0d want 0", tx_cnt - n0);
    end
    hold_busy = 1'b0;
    wait_idle(600, ok);
    bad = 0;
    for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
      if (tx_q[i] !== exp_stream[i]) bad++;
    end
    checks++;
    if (!ok || tx_cnt != 8 || bad != 0 || start_busy_cnt != 0) begin
      errors++;
      $display("FAIL bp_stream: idle=%0d starts=%0d bad_bytes=%0d tx_while_busy=%0d want 1 8 0 0",
               ok, tx_cnt, bad, start_busy_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    int bad;
    clear_log();
    done_en = 1'b0;
    send_byte(OP_RUN);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_early: err=%b want 0", bus.err);
    end
    cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.err === 1'b1) break;
    end
    checks++;
    if (cnt != TIMEOUT + 1) begin
      errors++;
      $display("FAIL tmo_cycles: err after %0d cycles want %0d", cnt, TIMEOUT + 1);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || tx_q.size() != 1 || tx_q[0] !== ERR_BYTE) begin
      errors++;
      $display("FAIL tmo_err_byte: idle=%0d count=%0d want 1 1 byte EE", ok, tx_q.size());
    end
    done_en = 1'b1;
    clear_log();
    send_byte(OP_RUN);
    wait_idle(600, ok);
    bad = 0;
    for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
      if (tx_q[i] !== exp_stream[i]) bad++;
    end
    checks++;
    if (!ok || tx_q.size() != 8 || bad != 0 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rerun: idle=%0d bytes=%0d bad=%0d err=%b want 1 8 0 1", ok, tx_q.size(), bad, bus.err);
    end
  endtask

  task automatic test_unknown();
    bit ok;
    pulse_reset();
    clear_log();
    send_byte(8'h7F);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL unk_err: err=%b want 1", bus.err);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || tx_q.size() != 1 || tx_q[0] !== ERR_BYTE || wr_q.size() != 0 || mstart_cnt != 0) begin
      errors++;
      $display("FAIL unk_reply: idle=%0d tx=%0d writes=%0d starts=%0d want 1 1 0 0",
               ok, tx_q.size(), wr_q.size(), mstart_cnt);
    end
  endtask

  task automatic test_drop();
    bit ok;
    int bad;
    pulse_reset();
    clear_log();
    send_byte(OP_RUN);
    send_byte(8'h33);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL drop_err: err=%b want 1", bus.err);
    end
    wait_idle(600, ok);
    bad = 0;
    for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
      if (tx_q[i] !== exp_stream[i]) bad++;
    end
    checks++;
    if (!ok || tx_q.size() != 8 || bad != 0 || wr_q.size() != 0 || mstart_cnt != 1) begin
      errors++;
      $display("FAIL drop_stream: idle=%0d bytes=%0d bad=%0d writes=%0d starts=%0d want 1 8 0 0 1",
               ok, tx_q.size(), bad, wr_q.size(), mstart_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    logic [10:0] e;
    clear_log();
    send_byte(OP_LOAD_A);
    send_byte(8'h41);
    send_byte(8'h42);
    @(negedge clk);
    bus.rx_data  = 8'h99;
    bus.rx_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 26'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0", outs());
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b0;
    clear_log();
    send_byte(OP_LOAD_A);
    for (int i = 0; i < N; i++) send_byte(8'h21 + 8'(i));
    wait_idle(100, ok);
    checks++;
    if (!ok || wr_q.size() != N || tx_q.size() != 1 || tx_q[0] !== ACK_BYTE) begin
      errors++;
      $display("FAIL midreset_reload: idle=%0d writes=%0d tx=%0d want 1 4 1", ok, wr_q.size(), tx_q.size());
    end else begin
      for (int i = 0; i < N; i++) begin
        e = {1'b0, 2'(i), 8'h21 + 8'(i)};
        checks++;
        if (wr_q[i] !== e) begin
          errors++;
          $display("FAIL midreset_log%0d: got %h want %h", i, wr_q[i], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load(OP_LOAD_A, 1'b0, 8'h01);
    test_load(OP_LOAD_B, 1'b1, 8'h11);
    test_run();
    test_back_to_back();
    test_timeout();
    test_unknown();
    test_drop();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
